// File: rtl/spi_pwm_loader.sv
// spi_pwm_loader: serial front end for the PWM stage.
// Receives a DATA_W-bit duty word over a 3-wire mode-0 SPI-style link (MSB first),
// synchronises the pins into the clk domain, checks the frame length and on a good
// frame updates data_out with a single-cycle load strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sclk       serial clock from the controller (async)
//   cs_n       active-low frame select (async)
//   mosi       serial data, sampled on sclk rise (async)
//   data_out   last accepted word, held between frames
//   load       one-cycle pulse when data_out has just been updated
//   frame_err  one-cycle pulse when a frame ends with a bit count other than DATA_W

`timescale 1ns / 1ps

module spi_pwm_loader #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic [DATA_W-1:0] data_out,
    output logic              load,
    output logic              frame_err
);

    localparam int unsigned      CntW    = $clog2(DATA_W + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);
    localparam logic [CntW-1:0] CntMax  = CntW'(DATA_W + 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e state_q, state_d;

    // Synchronisers and edge registers
    logic sclk_meta, sclk_s, sclk_prev;
    logic cs_meta, cs_s, cs_prev;
    logic mosi_meta, mosi_s;

    // The cs chain resets high, so cs_n held low across reset release would look like a
    // falling edge. armed_q only rises once a genuine high has reached cs_s, which keeps
    // that phantom edge from opening a frame.
    logic [1:0] settle_q;
    logic       armed_q;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load_q, load_d;
    logic              err_q, err_d;

    logic sclk_rise, cs_fall, cs_rise, frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            settle_q  <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_s    <= sclk_meta;
            sclk_prev <= sclk_s;
            cs_meta   <= cs_n;
            cs_s      <= cs_meta;
            cs_prev   <= cs_s;
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
            settle_q  <= {settle_q[0], 1'b1};
            armed_q   <= armed_q | (settle_q[1] & cs_s);
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign cs_fall     = ~cs_s & cs_prev;
    assign cs_rise     = cs_s & ~cs_prev;
    assign frame_start = cs_fall & armed_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StShift;
            StShift: if (cs_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and strobe logic
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    shift_d  = '0;
                    bitcnt_d = '0;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    if (bitcnt_q == CntFull) begin
                        data_d = shift_q;
                        load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise && !cs_s) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_s};
                    // Saturate so very long frames cannot wrap back to a valid count
                    if (bitcnt_q != CntMax) bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            load_q   <= load_d;
            err_q    <= err_d;
        end
    end

    assign data_out  = data_q;
    assign load      = load_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_pwm_loader.sv
// Self-checking bench for spi_pwm_loader. A frame-level model predicts, for each frame,
// whether a load or frame_err pulse appears three clk edges after cs_n rises and what
// data_out holds; a monitor compares every cycle. Inputs change on clk falling edges.

`timescale 1ns / 1ps

module tb_spi_pwm_loader;

    localparam int unsigned DATA_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              load;
    logic              frame_err;

    spi_pwm_loader #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .data_out  (data_out),
        .load      (load),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                tgt;
        bit                is_load;
        logic [DATA_W-1:0] word;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model_data = '0;
    bit                frame_open = 1'b0;
    int                cycle = 0;
    int                errors = 0;
    int                checks = 0;
    int                load_cnt = 0;
    int                err_cnt = 0;
    int                last_load_cyc = -1;
    int                last_rise_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Per-cycle compare against the frame model
    initial begin
        exp_t e;
        logic exp_l, exp_e;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            exp_l = 1'b0;
            exp_e = 1'b0;
            if (!rst && exp_q.size() > 0 && exp_q[0].tgt == cycle) begin
                e = exp_q.pop_front();
                if (e.is_load) begin
                    exp_l      = 1'b1;
                    model_data = e.word;
                end else begin
                    exp_e = 1'b1;
                end
            end
            check("load", {31'b0, load}, {31'b0, exp_l});
            check("frame_err", {31'b0, frame_err}, {31'b0, exp_e});
            check("data_out", {22'b0, data_out}, {22'b0, model_data});
            if (load) begin
                load_cnt++;
                last_load_cyc = cycle;
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: n bits of 'bits' MSB first, sclk half-period 'half' clks, cs_n high for
    // 'gap' clks afterwards. 'extra' adds an sclk rise together with the cs_n rise.
    // 'rst_after' > 0 pulses rst after that many bits with cs_n left low.
    task automatic send(input logic [31:0] bits, input int n, input int half,
                        input bit extra, input int rst_after, input int gap);
        cs_n       = 1'b0;
        frame_open = 1'b1;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
            if (rst_after == i + 1) begin
                rst        = 1'b1;
                exp_q.delete();
                model_data = '0;
                frame_open = 1'b0;
                tick(2);
                rst = 1'b0;
            end
        end
        tick(half);
        cs_n = 1'b1;
        if (extra) sclk = 1'b1;
        last_rise_cyc = cycle;
        if (frame_open) begin
            exp_q.push_back('{tgt: cycle + 3, is_load: (n == DATA_W), word: bits[DATA_W-1:0]});
        end
        frame_open = 1'b0;
        tick(gap);
        sclk = 1'b0;
    endtask

    initial begin
        int l0, e0, n, half, gap, ra;
        logic [31:0] bits;

        // Reset with inputs toggling, release with cs_n high
        repeat (8) begin
            @(negedge clk);
            sclk = 1'($urandom);
            cs_n = 1'($urandom);
            mosi = 1'($urandom);
        end
        @(negedge clk);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        check("reset_data", {22'b0, data_out}, 32'h0);
        check("reset_no_strobes", load_cnt + err_cnt, 0);

        // Good frame 0x2A5, sclk period 8
        l0 = load_cnt; e0 = err_cnt;
        send(32'h2A5, 10, 4, 1'b0, 0, 3);
        tick(2);
        check("good_data", {22'b0, data_out}, 32'h2A5);
        check("good_loads", load_cnt - l0, 1);
        check("good_errs", err_cnt - e0, 0);
        check("good_latency", last_load_cyc - last_rise_cyc, 3);

        // Short frame: 9 bits
        l0 = load_cnt; e0 = err_cnt;
        send(32'h0F3, 9, 4, 1'b0, 0, 3);
        tick(2);
        check("short_errs", err_cnt - e0, 1);
        check("short_loads", load_cnt - l0, 0);
        check("short_data", {22'b0, data_out}, 32'h2A5);

        // Long frame: 12 bits, first ten 0x155
        l0 = load_cnt; e0 = err_cnt;
        send({20'b0, 10'h155, 2'b10}, 12, 4, 1'b0, 0, 3);
        tick(2);
        check("long_errs", err_cnt - e0, 1);
        check("long_loads", load_cnt - l0, 0);
        check("long_data", {22'b0, data_out}, 32'h2A5);

        // 26 bits: a wrapping 4-bit counter would read 10 here
        l0 = load_cnt; e0 = err_cnt;
        send(32'h2AB_CDEF, 26, 3, 1'b0, 0, 3);
        tick(2);
        check("sat_errs", err_cnt - e0, 1);
        check("sat_loads", load_cnt - l0, 0);

        // Reset mid-frame after 5 bits; cs_n stays low across release
        l0 = load_cnt; e0 = err_cnt;
        send(32'h155, 10, 4, 1'b0, 5, 4);
        tick(2);
        check("midrst_loads", load_cnt - l0, 0);
        check("midrst_errs", err_cnt - e0, 0);
        check("midrst_data", {22'b0, data_out}, 32'h0);
        send(32'h3FF, 10, 4, 1'b0, 0, 3);
        tick(2);
        check("after_rst_data", {22'b0, data_out}, 32'h3FF);

        // Back-to-back, second frame with an sclk rise on the cs_n rise
        l0 = load_cnt; e0 = err_cnt;
        send(32'h000, 10, 4, 1'b0, 0, 3);
        send(32'h3FF, 10, 4, 1'b1, 0, 3);
        tick(2);
        check("b2b_loads", load_cnt - l0, 2);
        check("b2b_errs", err_cnt - e0, 0);
        check("b2b_data", {22'b0, data_out}, 32'h3FF);

        // Randomised frames
        for (int f = 0; f < 150; f++) begin
            n    = ($urandom_range(0, 9) < 6) ? 10 : int'($urandom_range(0, 14));
            half = int'($urandom_range(3, 6));
            gap  = int'($urandom_range(3, 6));
            bits = $urandom;
            ra   = ($urandom_range(0, 19) == 0 && n > 0) ? int'($urandom_range(1, n)) : 0;
            send(bits, n, half, 1'($urandom), ra, gap);
        end
        tick(6);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_pwm_loader.md
# spi_pwm_loader

Serial front end for the 10-bit PWM stage. Receives a duty-cycle word from an external controller over a 3-wire SPI-style link (mode 0, MSB first), synchronises it into the system clock domain, and validates the frame length. On a good frame it presents the word on `data_out` with a single-cycle `load` strobe, so it connects directly to the PWM block's `data_in`/`load` inputs.

## Interface
- `DATA_W`, default 10: word width; must equal the PWM `data_in` width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  serial clock from the controller; asynchronous to `clk`.
- `cs_n`  in  1  active-low frame select; asynchronous.
- `mosi`  in  1  serial data, valid around the rising edge of `sclk`; asynchronous.
- `data_out`  out  DATA_W  last accepted word; holds its value between frames.
- `load`  out  1  one-`clk` pulse when `data_out` has just been updated.
- `frame_err`  out  1  one-`clk` pulse when a frame ends with a bit count other than DATA_W.

## Operation
- **Synchronisers:** `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchroniser. The synchronised signals are `sclk_s`, `cs_s` and `mosi_s`.
- **Edge detection:** one extra register per signal holds the previous `sclk_s` and `cs_s`.
  - `sclk_rise` = `sclk_s` & !prev.
  - `cs_fall` = !`cs_s` & prev.
  - `cs_rise` = `cs_s` & !prev.
- **Reset values:**
  - Synchroniser and edge registers: `cs_n` chain to 1; `sclk` and `mosi` chains to 0.
  - `shift`, `bitcnt`, `data_out`, `load` and `frame_err` all reset to 0.
  - State resets to IDLE.
- **IDLE:**
  - On `cs_fall`: clear `shift` and `bitcnt`, then go to SHIFT.
  - All other events are ignored, including `cs_n` already low when reset is released. A frame starts only on a falling edge.
- **SHIFT:**
  - On `sclk_rise` while `cs_s` = 0: `shift` <= {`shift`[DATA_W-2:0], `mosi_s`}. `bitcnt` increments and saturates at DATA_W+1. `bitcnt` is 4 bits wide for the default width.
  - On `cs_rise`:
    - If `bitcnt` == DATA_W: `data_out` <= `shift` and `load` <= 1.
    - Otherwise: `frame_err` <= 1 and `data_out` is unchanged.
    - In both cases, return to IDLE.
  - An `sclk_rise` in the same cycle as `cs_rise` is not shifted, because `cs_s` is already 1.
- **Strobes:** `load` and `frame_err` are registered and self-clearing. Each is high for exactly one cycle and they are never high together.
- **Reset mid-frame:** the partial frame is discarded with no `load` and no `frame_err`. The block then needs a fresh `cs_n` falling edge.

## Timing
- **Input rate limit:** `sclk` high and low phases must each be at least 3 `clk` periods, so that edges are not lost after synchronisation.
- **`cs_n` edge separation:** `cs_n` must stay high for at least 3 `clk` periods between frames.
- **Latency:** `cs_n` pin rising to `load`/`frame_err` high is 3 `clk` edges: 2 synchroniser flops plus the registered strobe.
  - `data_out` changes on the same edge that raises `load`.
  - With the PWM stage registering `d` on that `load`, the new duty takes effect on the following `clk` edge.
- **`mosi` sampling:** `mosi` must be stable from 1 `clk` before the `sclk` rise at the pin until 3 `clk` after it. Both signals see the same synchroniser depth.
- **Back-to-back frames:** supported with no dead cycles beyond the `cs_n` high-time minimum.

## Test plan
- **Reset:** assert `rst` with random inputs toggling. Required: `data_out`=0, `load`=0, `frame_err`=0. Release with `cs_n`=1 and no strobes appear.
- **Good frame:** send 10 bits 0x2A5 (10'b1010100101), `sclk` period 8 `clk`. Required: `data_out`=0x2A5, `load` high for 1 cycle exactly 3 `clk` after `cs_n` rises, `frame_err` stays 0.
- **Short frame:** send 9 bits after a good 0x2A5. Required: one `frame_err` pulse, no `load`, `data_out` stays 0x2A5.
- **Long frame:** send 12 bits, the first ten being 0x155. Required: one `frame_err` pulse, no `load`, `data_out` unchanged.
- **Reset mid-frame:** pulse `rst` after 5 bits. Release it with `cs_n` still low, clock 5 more bits, then raise `cs_n`.
  - Required: no `load` and no `frame_err`, since the frame has no falling edge.
  - A following proper frame of 0x3FF must give `data_out`=0x3FF.
- **Back-to-back frames:** send 0x000 then 0x3FF with `cs_n` high for 3 `clk`. In the second frame, place an extra `sclk` rise in the same `clk` cycle as the `cs_n` rise.
  - Required: two `load` pulses, final `data_out`=0x3FF, no `frame_err`.
